// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with standard/FWFT read, threshold flags and sticky errors
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int FWFT = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign almost_full = level >= LW'(AF_THRESH);
  assign almost_empty = level <= LW'(AE_THRESH);
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= (overflow && !clr_err) || (wr_en && full && !flush);
      underflow <= (underflow && !clr_err) || (rd_en && empty && !flush);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level <= '0;
      end else begin
        if (wr_acc) wr_ptr <= inc(wr_ptr);
        if (rd_acc) rd_ptr <= inc(rd_ptr);
        if (wr_acc != rd_acc) level <= wr_acc ? level + 1'b1 : level - 1'b1;
      end
    end
  // FWFT output is gated to zero while empty so reset and flush present a clean word
  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem[rd_ptr];
    assign rd_valid = !empty;
  end else begin : g_std
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        data_out <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) data_out <= mem[rd_ptr];
      end
  end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: queue-model check of a standard 8-deep FIFO and a 5-deep FWFT FIFO
module tb_fifo_sync_param;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] d0_dout, d1_dout;
  logic d0_vld, d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un;
  logic d1_vld, d1_full, d1_empty, d1_af, d1_ae, d1_ov, d1_un;
  logic [3:0] d0_lvl;
  logic [2:0] d1_lvl;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  fifo_sync_param u0 (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .clr_err(clr_err), .data_out(d0_dout), .rd_valid(d0_vld),
    .full(d0_full), .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
    .level(d0_lvl), .overflow(d0_ov), .underflow(d0_un));

  fifo_sync_param #(.DEPTH(5), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .clr_err(clr_err), .data_out(d1_dout), .rd_valid(d1_vld),
    .full(d1_full), .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
    .level(d1_lvl), .overflow(d1_ov), .underflow(d1_un));

  logic [7:0] q0[$], q1[$];
  logic [7:0] m0_dout;
  logic m0_vld, m0_ov, m0_un, m1_ov, m1_un;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q0.delete(); q1.delete();
      m0_dout = '0; m0_vld = 0; m0_ov = 0; m0_un = 0; m1_ov = 0; m1_un = 0;
    end else begin
      automatic bit w0 = wr_en && q0.size() < 8, w1 = wr_en && q1.size() < 5;
      m0_ov = (m0_ov && !clr_err) || (wr_en && q0.size() == 8 && !flush);
      m0_un = (m0_un && !clr_err) || (rd_en && q0.size() == 0 && !flush);
      m1_ov = (m1_ov && !clr_err) || (wr_en && q1.size() == 5 && !flush);
      m1_un = (m1_un && !clr_err) || (rd_en && q1.size() == 0 && !flush);
      if (flush) begin
        q0.delete(); q1.delete(); m0_vld = 0;
      end else begin
        m0_vld = rd_en && q0.size() != 0;
        if (m0_vld) m0_dout = q0.pop_front();
        if (rd_en && q1.size() != 0) void'(q1.pop_front());
        if (w0) q0.push_back(data_in);
        if (w1) q1.push_back(data_in);
      end
    end
  end

  always @(negedge clk) begin
    logic [18:0] e0, a0;
    logic [17:0] e1, a1;
    logic [7:0] h1;
    h1 = '0;
    if (q1.size() != 0) h1 = q1[0];
    e0 = {m0_dout, m0_vld, q0.size() == 8, q0.size() == 0, q0.size() >= 6, q0.size() <= 2,
          4'(q0.size()), m0_ov, m0_un};
    a0 = {d0_dout, d0_vld, d0_full, d0_empty, d0_af, d0_ae, d0_lvl, d0_ov, d0_un};
    e1 = {h1, q1.size() != 0, q1.size() == 5, q1.size() == 0, q1.size() >= 4, q1.size() <= 1,
          3'(q1.size()), m1_ov, m1_un};
    a1 = {d1_dout, d1_vld, d1_full, d1_empty, d1_af, d1_ae, d1_lvl, d1_ov, d1_un};
    total += 2;
    if (a0 !== e0) begin bad++; $display("FAIL std_outputs t=%0t got=%h exp=%h", $time, a0, e0); end
    if (a1 !== e1) begin bad++; $display("FAIL fwft_outputs t=%0t got=%h exp=%h", $time, a1, e1); end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin bad++; $display("FAIL %s got=%0h exp=%0h", n, a, e); end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f, input logic c);
    wr_en = w; data_in = d; rd_en = r; flush = f; clr_err = c;
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    chk("reset_empty", d0_empty, 1); chk("reset_full", d0_full, 0);
    chk("reset_ae", d0_ae, 1); chk("reset_level", d0_lvl, 0);
    @(posedge clk); #1 reset = 0;
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
    chk("fill_level", d0_lvl, 8); chk("fill_full", d0_full, 1);
    step(1, 8'h09, 0, 0, 0);
    chk("overflow_set", d0_ov, 1); chk("overflow_level", d0_lvl, 8);
    step(0, 0, 0, 0, 1);
    chk("overflow_clr", d0_ov, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 0, 0);
      chk("read_data", d0_dout, i); chk("read_valid", d0_vld, 1);
    end
    chk("drain_empty", d0_empty, 1);
    step(0, 0, 1, 0, 0);
    chk("underflow_set", d0_un, 1); chk("underflow_novalid", d0_vld, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 8'(8'h10 + i), 0, 0, 0);
      chk("fwft_head", d1_dout, 8'h10 + i); chk("fwft_valid", d1_vld, 1);
      step(0, 0, 1, 0, 0);
      chk("wrap_data", d0_dout, 8'h10 + i);
    end
    for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 8'(8'h30 + k), 1, 0, 0);
      chk("simul_level", d0_lvl, 3); chk("simul_data", d0_dout, k < 3 ? 8'h20 + k : 8'h30);
    end
    step(0, 0, 0, 1, 0);
    step(1, 8'hA5, 0, 0, 0);
    chk("fwft_a5_data", d1_dout, 8'hA5); chk("fwft_a5_valid", d1_vld, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    chk("af_level6", d0_af, 1);
    chk("d1_overflow", d1_ov, 1);
    step(1, 8'h77, 0, 1, 0);
    chk("flush_level", d0_lvl, 0); chk("flush_empty", d0_empty, 1);
    chk("flush_keeps_ov", d1_ov, 1); chk("flush_d0_ov", d0_ov, 0);
    for (int i = 0; i < 3; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
    @(posedge clk); #3 reset = 1;
    #1 chk("async_reset_empty", d0_empty, 1); chk("async_reset_level", d0_lvl, 0);
    chk("async_reset_fwft", d1_vld, 0);
    @(posedge clk); #2 reset = 0;
    for (int n = 0; n < 3000; n++) begin
      automatic int wp = (n / 300) % 2 ? 80 : 35;
      reset = $urandom_range(0, 299) == 0;
      step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
    end
    reset = 0;
    step(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
